// File: rtl/hazard_sequencer.sv
// Load-use stall and taken-branch flush sequencer. Outputs are combinational in the same cycle as the inputs; state and counters are registered.
// No backpressure: a stall holds PC and IF/ID for one cycle per load, and a redirect runs FLUSH_LEN flush cycles.
module hazard_sequencer #(
  parameter int FLUSH_LEN = 2,
  parameter int ZERO_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rm,
  input  logic        id_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_pcsrc,
  input  logic [63:0] mem_branch_addr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush,
  output logic        pc_sel,
  output logic [63:0] pc_target,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01
  } state_t;

  localparam logic [4:0] LP_ZERO_REG   = 5'(ZERO_REG);
  localparam logic [2:0] LP_FLUSH_INIT = 3'(FLUSH_LEN - 1);

  state_t      r_state;
  logic [2:0]  r_flush_left;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic w_hazard;
  logic w_redirect;
  logic w_stall_evt;

  // The zero register is hardwired, so a load targeting it can never feed a consumer.
  assign w_hazard = ex_mem_read & id_valid & (ex_rd != LP_ZERO_REG) &
                    ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));

  assign w_redirect  = (r_state == ST_RUN) & mem_pcsrc;
  assign w_stall_evt = (r_state == ST_RUN) & ~mem_pcsrc & w_hazard;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b1;
    flush       = 1'b1;
    pc_sel      = 1'b0;
    pc_target   = 64'd0;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (mem_pcsrc) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b1;
            flush       = 1'b1;
            pc_sel      = 1'b1;
            pc_target   = mem_branch_addr;
          end else if (w_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            flush       = 1'b0;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
            flush       = 1'b0;
          end
        end
        ST_FLUSH: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_bubble = 1'b1;
          flush       = 1'b1;
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_flush_left <= 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            r_state      <= ST_FLUSH;
            r_flush_left <= LP_FLUSH_INIT;
          end
        end
        ST_FLUSH: begin
          if (r_flush_left == 3'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_left <= r_flush_left - 3'd1;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_flush_left <= 3'd0;
        end
      endcase
    end
  end

  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_redirect && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a behavioural model checked every negedge plus literal spot checks.
module tb_hazard_sequencer;

  localparam int FLUSH_LEN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rn = '0;
  logic [4:0]  id_rm = '0;
  logic        id_uses_rm = 1'b0;
  logic        id_valid = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        mem_pcsrc = 1'b0;
  logic [63:0] mem_branch_addr = '0;
  logic        pc_write, ifid_write, idex_bubble, flush, pc_sel;
  logic [63:0] pc_target;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: remaining flush cycles and event tallies.
  int flush_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_sequencer #(.FLUSH_LEN(FLUSH_LEN), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm), .id_valid(id_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_pcsrc(mem_pcsrc), .mem_branch_addr(mem_branch_addr),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush(flush), .pc_sel(pc_sel), .pc_target(pc_target), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit load_use();
    return ex_mem_read && id_valid && (ex_rd != 5'd31) &&
           ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_left = 0;
      m_stall = 0;
      m_flush = 0;
    end else if (flush_left > 0) begin
      flush_left = flush_left - 1;
    end else if (mem_pcsrc) begin
      flush_left = FLUSH_LEN;
      if (m_flush < 65535) m_flush = m_flush + 1;
    end else if (load_use()) begin
      if (m_stall < 65535) m_stall = m_stall + 1;
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;   // {pc_write, ifid_write, idex_bubble, flush, pc_sel, in_flush}
    logic [63:0] tgt;
    tgt = 64'd0;
    if (!rst_n)              e = 6'b001100;
    else if (flush_left > 0) e = 6'b111101;
    else if (mem_pcsrc) begin
      e = 6'b111110;
      tgt = mem_branch_addr;
    end
    else if (load_use())     e = 6'b001000;
    else                     e = 6'b110000;
    check("pc_write",    64'(pc_write),    64'(e[5]));
    check("ifid_write",  64'(ifid_write),  64'(e[4]));
    check("idex_bubble", 64'(idex_bubble), 64'(e[3]));
    check("flush",       64'(flush),       64'(e[2]));
    check("pc_sel",      64'(pc_sel),      64'(e[1]));
    check("pc_target",   pc_target,        tgt);
    check("state",       64'(state),       64'({1'b0, e[0]}));
    check("stall_cnt",   64'(stall_cnt),   64'(m_stall));
    check("flush_cnt",   64'(flush_cnt),   64'(m_flush));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_mem_read = 1'b0; id_valid = 1'b0; id_uses_rm = 1'b0;
    ex_rd = '0; id_rn = '0; id_rm = '0; mem_pcsrc = 1'b0; mem_branch_addr = '0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                          input logic use_rm, input logic vld);
    ex_mem_read = 1'b1; ex_rd = rd; id_rn = rn; id_rm = rm; id_uses_rm = use_rm; id_valid = vld;
  endtask

  int n;

  initial begin
    repeat (2) cyc();
    #2;
    check("lit_reset_pc_write", 64'(pc_write), 64'd0);
    check("lit_reset_flush", 64'(flush), 64'd1);
    cyc();
    rst_n = 1'b1;

    // Load-use on rn: one stall cycle.
    cyc();
    set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    #2;
    check("lit_stall_pc_write", 64'(pc_write), 64'd0);
    check("lit_stall_bubble", 64'(idex_bubble), 64'd1);
    check("lit_stall_cnt_before", 64'(stall_cnt), 64'd0);
    cyc();
    clear_in();
    check("lit_stall_cnt_after", 64'(stall_cnt), 64'd1);

    // Zero register never stalls.
    set_load(5'd31, 5'd31, 5'd0, 1'b0, 1'b1);
    #2;
    check("lit_xzr_pc_write", 64'(pc_write), 64'd1);
    cyc();
    check("lit_xzr_stall_cnt", 64'(stall_cnt), 64'd1);

    // rm dependency only counts when rm is read; invalid slot never stalls.
    set_load(5'd7, 5'd0, 5'd7, 1'b0, 1'b1); cyc();
    set_load(5'd7, 5'd0, 5'd7, 1'b1, 1'b0); cyc();
    set_load(5'd7, 5'd0, 5'd7, 1'b1, 1'b1); cyc();
    clear_in(); cyc();
    check("lit_rm_stall_cnt", 64'(stall_cnt), 64'd2);

    // Branch with concurrent hazard, pcsrc and hazard held through FLUSH.
    set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    mem_pcsrc = 1'b1; mem_branch_addr = 64'h40;
    #2;
    check("lit_br_pc_sel", 64'(pc_sel), 64'd1);
    check("lit_br_target", pc_target, 64'h40);
    check("lit_br_flush", 64'(flush), 64'd1);
    cyc();
    n = 0;
    while (state == 2'b01 && n < 10) begin
      n++;
      cyc();
    end
    clear_in();
    check("lit_flush_cycles", 64'(n), 64'd2);
    check("lit_br_flush_cnt", 64'(flush_cnt), 64'd1);
    check("lit_br_stall_cnt", 64'(stall_cnt), 64'd2);
    cyc();

    // Plain branch to a wide address.
    mem_pcsrc = 1'b1; mem_branch_addr = 64'h1234_5678_9ABC_DEF0;
    cyc();
    clear_in();
    repeat (3) cyc();
    check("lit_br2_flush_cnt", 64'(flush_cnt), 64'd2);

    // Asynchronous reset in first FLUSH cycle.
    mem_pcsrc = 1'b1; mem_branch_addr = 64'h40;
    cyc();
    clear_in();
    #2;
    rst_n = 1'b0;
    #1;
    check("lit_arst_state", 64'(state), 64'd0);
    check("lit_arst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("lit_arst_flush_cnt", 64'(flush_cnt), 64'd0);
    check("lit_arst_pc_write", 64'(pc_write), 64'd0);
    check("lit_arst_flush", 64'(flush), 64'd1);
    check("lit_arst_target", pc_target, 64'd0);
    cyc();
    rst_n = 1'b1;
    #2;
    check("lit_post_rst_state", 64'(state), 64'd0);
    check("lit_post_rst_pc_write", 64'(pc_write), 64'd1);
    check("lit_post_rst_flush", 64'(flush), 64'd0);
    cyc();

    // Saturation of the stall counter.
    set_load(5'd9, 5'd9, 5'd0, 1'b0, 1'b1);
    repeat (65536) cyc();
    check("lit_sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);
    cyc();
    check("lit_sat_stall_hold", 64'(stall_cnt), 64'hFFFF);
    clear_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
